// File: rtl/fx_sched_pkg.sv
// Shared types, sample limits and saturation helper for the effects-chain scheduler.
package fx_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_ISSUE,
    ST_WAIT,
    ST_OUT
  } sched_state_e;

  localparam int SAMPLE_W_DEF = 12;
  localparam int SAMPLE_MAX   = (2 ** (SAMPLE_W_DEF - 1)) - 1;
  localparam int SAMPLE_MIN   = -(2 ** (SAMPLE_W_DEF - 1));

  // Clamp a sign-extended value to the signed range of a width-bit sample.
  function automatic logic signed [31:0] sat_sample(input logic signed [31:0] value,
                                                    input int                 width);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (width - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/fx_voice_pick.sv
// Lowest-index priority encoder over the pending-voice mask.
module fx_voice_pick #(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_VOICES-1:0] pending,
  output logic [IDX_W-1:0]      k,
  output logic                  none_pending
);

  // Scan downward so the lowest set index is the last one written.
  always_comb begin
    k            = '0;
    none_pending = 1'b1;
    for (int i = NUM_VOICES - 1; i >= 0; i--) begin
      if (pending[i]) begin
        k            = IDX_W'(i);
        none_pending = 1'b0;
      end
    end
  end

endmodule

// File: rtl/fx_chain_scheduler.sv
// Per-frame voice scheduler for the shared effects chain; mixes and saturates the frame.
// Optional peak meter enabled by defining FX_SCHED_PEAK_EN.
module fx_chain_scheduler
  import fx_sched_pkg::*;
#(
  parameter int NUM_VOICES  = 4,
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           new_sample_ready,
  input  logic [NUM_VOICES-1:0]          voice_active,
  input  logic [NUM_VOICES-1:0]          voice_fx_en,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_samples,
  output logic                           chain_start,
  output logic [SAMPLE_W-1:0]            chain_sample,
  input  logic                           chain_done,
  input  logic [SAMPLE_W-1:0]            chain_result,
  output logic [SAMPLE_W-1:0]            mix_out,
  output logic                           mix_ready,
  output logic                           timeout_err,
  output logic                           overrun
`ifdef FX_SCHED_PEAK_EN
  ,
  output logic [SAMPLE_W-1:0]            peak_level,
  input  logic                           peak_clear
`endif
);

  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  sched_state_e              state, state_next;
  logic [SAMPLE_W-1:0]       sample_q [NUM_VOICES];
  logic [NUM_VOICES-1:0]     pending;
  logic [NUM_VOICES-1:0]     fxmask;
  logic signed [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]          wait_cnt;

  logic [IDX_W-1:0]          pick_k;
  logic                      none_pending;
  logic [SAMPLE_W-1:0]       sel_sample;
  logic                      add_en;
  logic [SAMPLE_W-1:0]       add_val;
  logic                      clear_k;
  logic                      drop_k;

  fx_voice_pick #(
    .NUM_VOICES (NUM_VOICES),
    .IDX_W      (IDX_W)
  ) u_pick (
    .pending      (pending),
    .k            (pick_k),
    .none_pending (none_pending)
  );

  assign sel_sample = sample_q[pick_k];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_next   = state;
    chain_start  = 1'b0;
    chain_sample = '0;
    add_en       = 1'b0;
    add_val      = '0;
    clear_k      = 1'b0;
    drop_k       = 1'b0;
    case (state)
      ST_IDLE: if (new_sample_ready) state_next = ST_SCAN;
      ST_SCAN: begin
        if (none_pending) begin
          state_next = ST_OUT;
        end else if (fxmask[pick_k]) begin
          state_next = ST_ISSUE;
        end else begin
          add_en  = 1'b1;
          add_val = sel_sample;
          clear_k = 1'b1;
        end
      end
      ST_ISSUE: begin
        chain_start  = 1'b1;
        chain_sample = sel_sample;
        state_next   = ST_WAIT;
      end
      ST_WAIT: begin
        // A done arriving on the timeout cycle still counts.
        if (chain_done) begin
          add_en     = 1'b1;
          add_val    = chain_result;
          clear_k    = 1'b1;
          state_next = ST_SCAN;
        end else if (wait_cnt == CNT_LAST) begin
          clear_k    = 1'b1;
          drop_k     = 1'b1;
          state_next = ST_SCAN;
        end
      end
      ST_OUT:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // NOTE: the sample latch is plain storage with no reset; it is always rewritten before being read.
  always_ff @(posedge clock) begin
    if (state == ST_IDLE && new_sample_ready) begin
      for (int i = 0; i < NUM_VOICES; i++) sample_q[i] <= voice_samples[i*SAMPLE_W +: SAMPLE_W];
    end
  end

  // NOTE: non-blocking assignments throughout, so every register sees pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pending     <= '0;
      fxmask      <= '0;
      acc         <= '0;
      wait_cnt    <= '0;
      mix_out     <= '0;
      mix_ready   <= 1'b0;
      timeout_err <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      state     <= state_next;
      mix_ready <= (state == ST_OUT);
      if (state == ST_IDLE && new_sample_ready) begin
        pending <= voice_active;
        fxmask  <= voice_fx_en;
        acc     <= '0;
      end else begin
        if (add_en) acc <= acc + {{(ACC_W - SAMPLE_W){add_val[SAMPLE_W-1]}}, add_val};
        if (clear_k) pending[pick_k] <= 1'b0;
      end
      if (new_sample_ready && state != ST_IDLE) overrun <= 1'b1;
      if (drop_k) timeout_err <= 1'b1;
      if (state == ST_ISSUE) wait_cnt <= '0;
      else if (state == ST_WAIT) wait_cnt <= wait_cnt + 1'b1;
      if (state == ST_OUT) mix_out <= SAMPLE_W'(sat_sample(32'(acc), SAMPLE_W));
    end
  end

`ifdef FX_SCHED_PEAK_EN
  logic signed [31:0] acc_abs;

  // Saturating |acc| equals |sat(acc)| with the most negative code folded to max.
  always_comb acc_abs = (acc < 0) ? -32'(acc) : 32'(acc);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      peak_level <= '0;
    end else if (peak_clear) begin
      peak_level <= '0;
    end else if (state == ST_OUT && SAMPLE_W'(sat_sample(acc_abs, SAMPLE_W)) > peak_level) begin
      peak_level <= SAMPLE_W'(sat_sample(acc_abs, SAMPLE_W));
    end
  end
`endif

endmodule

// File: tb/tb_fx_chain_scheduler.sv
// Randomized self-checking bench for fx_chain_scheduler with an identity/silent chain model.
module tb_fx_chain_scheduler;

  localparam int NV = 4;
  localparam int SW = 12;
  localparam int TO = 16;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               new_sample_ready = 1'b0;
  logic [NV-1:0]      voice_active = '0;
  logic [NV-1:0]      voice_fx_en = '0;
  logic [NV*SW-1:0]   voice_samples = '0;
  logic               chain_start;
  logic [SW-1:0]      chain_sample;
  logic               chain_done;
  logic [SW-1:0]      chain_result = '0;
  logic [SW-1:0]      mix_out;
  logic               mix_ready;
  logic               timeout_err;
  logic               overrun;
  logic               model_done = 1'b0;
  logic               force_done = 1'b0;
`ifdef FX_SCHED_PEAK_EN
  logic [SW-1:0]      peak_level;
  logic               peak_clear = 1'b0;
  int                 exp_peak = 0;
`endif

  assign chain_done = model_done | force_done;

  fx_chain_scheduler #(
    .NUM_VOICES  (NV),
    .SAMPLE_W    (SW),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .new_sample_ready (new_sample_ready),
    .voice_active     (voice_active),
    .voice_fx_en      (voice_fx_en),
    .voice_samples    (voice_samples),
    .chain_start      (chain_start),
    .chain_sample     (chain_sample),
    .chain_done       (chain_done),
    .chain_result     (chain_result),
    .mix_out          (mix_out),
    .mix_ready        (mix_ready),
    .timeout_err      (timeout_err),
    .overrun          (overrun)
`ifdef FX_SCHED_PEAK_EN
    ,
    .peak_level       (peak_level),
    .peak_clear       (peak_clear)
`endif
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-frame stimulus description; lat 0 means the chain never answers.
  logic [NV-1:0] f_act, f_fx;
  int            f_s   [NV];
  int            f_lat [NV];

  logic [SW-1:0] exp_start_q [$];
  int            lat_q [$];
  int            start_cnt = 0;
  int            mix_cnt = 0;
  int            chain_lat = 0;
  bit            chain_busy = 1'b0;
  bit            exp_timeout = 1'b0;
  bit            exp_overrun = 1'b0;

  // Chain model and pulse monitors, evaluated mid-cycle.
  always @(negedge clock) begin
    model_done = 1'b0;
    if (mix_ready) mix_cnt++;
    if (chain_start) begin
      start_cnt++;
      if (exp_start_q.size() > 0)
        check("chain_sample", $signed(chain_sample), $signed(exp_start_q.pop_front()));
      chain_lat    = (lat_q.size() > 0) ? lat_q.pop_front() : 0;
      chain_result = chain_sample;
      chain_busy   = (chain_lat != 0);
    end else if (chain_busy) begin
      chain_lat--;
      if (chain_lat == 0) begin
        model_done = 1'b1;
        chain_busy = 1'b0;
      end
    end
  end

  function automatic int clamp(input int v);
    if (v > 2047) return 2047;
    if (v < -2048) return -2048;
    return v;
  endfunction

  task automatic run_frame(input bit extra_strobe);
    int  sum, n_exp, n_starts, n, exp_mix;
    bit  drop, seen;
    sum = 0; n_exp = 2; n_starts = 0; drop = 1'b0;
    for (int v = 0; v < NV; v++) begin
      if (f_act[v]) begin
        if (!f_fx[v]) begin
          sum += f_s[v];
          n_exp += 1;
        end else begin
          n_starts++;
          exp_start_q.push_back(SW'(f_s[v]));
          lat_q.push_back(f_lat[v]);
          if (f_lat[v] != 0 && f_lat[v] <= TO) begin
            sum += f_s[v];
            n_exp += 2 + f_lat[v];
          end else begin
            drop = 1'b1;
            n_exp += 2 + TO;
          end
        end
      end
    end
    exp_mix = clamp(sum);
    exp_timeout |= drop;
    exp_overrun |= extra_strobe;

    @(posedge clock); #1;
    voice_active = f_act;
    voice_fx_en  = f_fx;
    for (int v = 0; v < NV; v++) voice_samples[v*SW +: SW] = SW'(f_s[v]);
    new_sample_ready = 1'b1;
    mix_cnt = 0;
    start_cnt = 0;
    @(posedge clock); #1;
    new_sample_ready = 1'b0;
    voice_active  = NV'($urandom);
    voice_fx_en   = NV'($urandom);
    voice_samples = {$urandom, $urandom};

    n = 0; seen = 1'b0;
    while (!seen && n < 400) begin
      new_sample_ready = extra_strobe && (n == 2);
      @(posedge clock); #1;
      n++;
      if (mix_ready) seen = 1'b1;
    end
    new_sample_ready = 1'b0;
    check("mix_latency", n, n_exp);
    check("mix_out", $signed(mix_out), exp_mix);
    repeat (2) @(posedge clock);
    #1;
    check("mix_ready_pulses", mix_cnt, 1);
    check("start_count", start_cnt, n_starts);
    check("timeout_err", timeout_err, exp_timeout);
    check("overrun", overrun, exp_overrun);
`ifdef FX_SCHED_PEAK_EN
    if ((exp_mix < 0 ? clamp(-exp_mix) : exp_mix) > exp_peak)
      exp_peak = exp_mix < 0 ? clamp(-exp_mix) : exp_mix;
    check("peak_level", peak_level, exp_peak);
`endif
    exp_start_q.delete();
    lat_q.delete();
  endtask

  task automatic set_frame(input logic [NV-1:0] act, input logic [NV-1:0] fx,
                           input int s0, input int s1, input int s2, input int s3,
                           input int lat);
    f_act = act;
    f_fx  = fx;
    f_s[0] = s0; f_s[1] = s1; f_s[2] = s2; f_s[3] = s3;
    for (int v = 0; v < NV; v++) f_lat[v] = lat;
  endtask

  task automatic check_quiet_outputs(input string tag);
    check({tag, "_mix_out"}, mix_out, 0);
    check({tag, "_mix_ready"}, mix_ready, 0);
    check({tag, "_timeout_err"}, timeout_err, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_chain_start"}, chain_start, 0);
    check({tag, "_chain_sample"}, chain_sample, 0);
  endtask

  initial begin
    #12;
    check_quiet_outputs("reset");
    @(posedge clock); #1;
    reset_n = 1'b1;

    set_frame(4'b0000, 4'b0000, 5, 6, 7, 8, 1);
    run_frame(1'b0);

`ifdef FX_SCHED_PEAK_EN
    set_frame(4'b0001, 4'b0000, -300, 0, 0, 0, 1);
    run_frame(1'b0);
    set_frame(4'b0001, 4'b0000, 120, 0, 0, 0, 1);
    run_frame(1'b0);
    check("peak_after_two", peak_level, 300);
    @(posedge clock); #1;
    peak_clear = 1'b1;
    @(posedge clock); #1;
    peak_clear = 1'b0;
    exp_peak = 0;
    check("peak_cleared", peak_level, 0);
`endif

    set_frame(4'b0011, 4'b0011, 100, 200, 0, 0, 5);
    run_frame(1'b0);
    set_frame(4'b1111, 4'b0000, 2000, 2000, 2000, 2000, 1);
    run_frame(1'b0);
    set_frame(4'b1111, 4'b0000, -2000, -2000, -2000, -2000, 1);
    run_frame(1'b0);
    set_frame(4'b0011, 4'b0001, 700, 50, 0, 0, 0);
    run_frame(1'b0);

    for (int f = 0; f < 40; f++) begin
      f_act = NV'($urandom);
      f_fx  = NV'($urandom);
      for (int v = 0; v < NV; v++) begin
        f_s[v]   = int'($urandom_range(0, 4095)) - 2048;
        f_lat[v] = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 8));
      end
      run_frame(1'b0);
    end

    set_frame(4'b0101, 4'b0001, 321, 0, -21, 0, 5);
    run_frame(1'b1);

    // Reset asserted while waiting on a chain that never answers.
    set_frame(4'b0001, 4'b0001, 77, 0, 0, 0, 0);
    exp_start_q.push_back(SW'(77));
    lat_q.push_back(0);
    @(posedge clock); #1;
    voice_active = f_act;
    voice_fx_en  = f_fx;
    voice_samples = '0;
    voice_samples[SW-1:0] = SW'(77);
    new_sample_ready = 1'b1;
    @(posedge clock); #1;
    new_sample_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    check_quiet_outputs("midframe_reset");
    exp_timeout = 1'b0;
    exp_overrun = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_start_q.delete();
    lat_q.delete();
    start_cnt = 0;
    mix_cnt = 0;
    repeat (2) @(posedge clock);
    #1;
    force_done = 1'b1;
    @(posedge clock); #1;
    force_done = 1'b0;
    repeat (6) @(posedge clock);
    #1;
    check("post_reset_mix_ready", mix_cnt, 0);
    check("post_reset_starts", start_cnt, 0);
    check("post_reset_mix_out", mix_out, 0);
    check("post_reset_timeout", timeout_err, 0);
`ifdef FX_SCHED_PEAK_EN
    exp_peak = 0;
`endif

    set_frame(4'b0110, 4'b0100, 0, 33, 44, 0, 3);
    run_frame(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
